fp_sequencer: RTL and testbench

- Forward-pass sequencer between the control unit and the neuron tile.
- On each `do_fp` request it walks every layer in order, and within each layer every neuron group.
- For each group it issues one tile operation and waits for the tile to finish it.
- After the final group of the final layer it pulses `fp_done` back to the control unit.

---
 rtl/fp_sequencer_if.sv | 28 ++
 rtl/fp_sequencer.sv | 158 +++++++++++++++
 tb/tb_fp_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sequencer_if.sv
// Forward-pass sequencer bus: start/done handshake with the control unit
// plus the group issue/complete handshake with the neuron tile.
// master: control unit and tile side; slave: the sequencer.
interface fp_sequencer_if #(
    parameter int GROUP = 8
);
    localparam int CW = $clog2(GROUP + 1);

    logic          do_fp;
    logic          fp_done;
    logic          busy;
    logic          tile_start;
    logic [1:0]    tile_layer;
    logic [7:0]    tile_base;
    logic [CW-1:0] tile_count;
    logic          tile_done;
    logic          seq_err;

    modport master (
        output do_fp, tile_done,
        input  fp_done, busy, tile_start, tile_layer, tile_base, tile_count, seq_err
    );

    modport slave (
        input  do_fp, tile_done,
        output fp_done, busy, tile_start, tile_layer, tile_base, tile_count, seq_err
    );
endinterface

// File: rtl/fp_sequencer.sv
// Forward-pass sequencer: walks every layer and neuron group, issuing one
// tile operation per group and pulsing fp_done after the last one.
// Optional macro SEQ_TIMEOUT_EN adds a per-operation watchdog that aborts
// the pass with a seq_err pulse.
//
// state | meaning
// IDLE  | waiting for do_fp
// ISSUE | tile_start pulse for the current group (one cycle)
// WAIT  | waiting for tile_done of the issued group
// DONE  | fp_done pulse (one cycle)
module fp_sequencer #(
    parameter int NUM_LAYERS     = 2,
    parameter int LAYER0_NEURONS = 30,
    parameter int LAYER1_NEURONS = 10,
    parameter int LAYER2_NEURONS = 0,
    parameter int LAYER3_NEURONS = 0,
    parameter int GROUP          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic          clk,
    input logic          rst,
    fp_sequencer_if.slave bus
);
    localparam int CW = $clog2(GROUP + 1);
    localparam logic [7:0] LAYER_N [4] = '{8'(LAYER0_NEURONS), 8'(LAYER1_NEURONS),
                                           8'(LAYER2_NEURONS), 8'(LAYER3_NEURONS)};

    if (GROUP < 1 || GROUP > 255) begin : g_bad_group
        $error("fp_sequencer: GROUP must be in 1..255");
    end
    if (NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_bad_layers
        $error("fp_sequencer: NUM_LAYERS must be in 1..4");
    end
    if (LAYER0_NEURONS > 255 || LAYER1_NEURONS > 255 ||
        LAYER2_NEURONS > 255 || LAYER3_NEURONS > 255) begin : g_bad_neurons
        $error("fp_sequencer: layer neuron counts must not exceed 255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fp_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    layer_q;
    logic [7:0]    base_q;
    logic [CW-1:0] count_q;

    logic          adv_valid;
    logic [1:0]    adv_layer;
    logic [7:0]    adv_base;
    logic [CW-1:0] adv_count;
    logic [8:0]    adv_rem;
    int            first_layer;
    logic          load;
    logic          timeout;

    // Next group to issue: the following group of this layer, else group 0
    // of the next non-empty layer (from layer 0 when starting a pass).
    always_comb begin
        adv_valid   = 1'b0;
        adv_layer   = layer_q;
        adv_base    = base_q;
        first_layer = 0;
        if (state != IDLE &&
            ({1'b0, base_q} + 9'(GROUP) < {1'b0, LAYER_N[layer_q]})) begin
            adv_valid = 1'b1;
            adv_base  = base_q + 8'(GROUP);
        end else begin
            first_layer = (state == IDLE) ? 0 : int'(layer_q) + 1;
            adv_base    = 8'd0;
            for (int i = 3; i >= 0; i--) begin
                if (i >= first_layer && i < NUM_LAYERS && LAYER_N[i] != 8'd0) begin
                    adv_valid = 1'b1;
                    adv_layer = 2'(i);
                end
            end
        end
        adv_rem   = {1'b0, LAYER_N[adv_layer]} - {1'b0, adv_base};
        adv_count = (adv_rem > 9'(GROUP)) ? CW'(GROUP) : CW'(adv_rem);
    end

    assign load = (state == IDLE && bus.do_fp) || (state == WAIT && bus.tile_done);

`ifdef SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    logic          seq_err_q;

    assign timeout = (state == WAIT) && !bus.tile_done && (wd_q == WW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles of the current operation; error is flagged
    // in the IDLE cycle that follows the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= timeout;
            if (state == WAIT) wd_q <= wd_q + 1'b1;
            else               wd_q <= '0;
        end
    end

    assign bus.seq_err = seq_err_q;
`else
    assign timeout     = 1'b0;
    assign bus.seq_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; an empty remainder of the pass goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.do_fp) state_nxt = adv_valid ? ISSUE : DONE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.tile_done) state_nxt = adv_valid ? ISSUE : DONE;
                else if (timeout)  state_nxt = IDLE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Group descriptor registers; cleared when a pass ends or aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_q <= 2'd0;
            base_q  <= 8'd0;
            count_q <= '0;
        end else if (load && adv_valid) begin
            layer_q <= adv_layer;
            base_q  <= adv_base;
            count_q <= adv_count;
        end else if (state == DONE || timeout) begin
            layer_q <= 2'd0;
            base_q  <= 8'd0;
            count_q <= '0;
        end
    end

    // Outputs decoded from the state and descriptor registers.
    always_comb begin
        bus.tile_start = (state == ISSUE);
        bus.fp_done    = (state == DONE);
        bus.busy       = (state != IDLE);
        bus.tile_layer = layer_q;
        bus.tile_base  = base_q;
        bus.tile_count = count_q;
    end
endmodule

// File: tb/tb_fp_sequencer.sv
// Bench for fp_sequencer: two instances (default layers, and layer 1 empty),
// expected group lists built from the layer sizes with plain arithmetic.
module tb_fp_sequencer;
    localparam int G  = 8;
    localparam int CW = $clog2(G + 1);

    typedef struct {
        int l;
        int b;
        int c;
    } grp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic do_fp_v = 1'b0;
    logic tile_done_v = 1'b0;
    int   sel = 0;
    int   checks = 0;
    int   errors = 0;
    grp_t exp_q[$];

    int na[4] = '{30, 10, 0, 0};
    int nb[4] = '{30, 0, 0, 0};

    always #5 clk = ~clk;

    fp_sequencer_if #(.GROUP(G)) bus_a ();
    fp_sequencer_if #(.GROUP(G)) bus_b ();

    assign bus_a.do_fp     = do_fp_v && (sel == 0);
    assign bus_a.tile_done = tile_done_v && (sel == 0);
    assign bus_b.do_fp     = do_fp_v && (sel == 1);
    assign bus_b.tile_done = tile_done_v && (sel == 1);

    fp_sequencer #(.NUM_LAYERS(2), .LAYER0_NEURONS(30), .LAYER1_NEURONS(10),
                   .LAYER2_NEURONS(0), .LAYER3_NEURONS(0), .GROUP(G),
                   .TIMEOUT_CYCLES(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    fp_sequencer #(.NUM_LAYERS(2), .LAYER0_NEURONS(30), .LAYER1_NEURONS(0),
                   .LAYER2_NEURONS(0), .LAYER3_NEURONS(0), .GROUP(G),
                   .TIMEOUT_CYCLES(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic          m_start, m_done, m_busy, m_err;
    logic [1:0]    m_layer;
    logic [7:0]    m_base;
    logic [CW-1:0] m_count;

    always_comb begin
        if (sel == 1) begin
            m_start = bus_b.tile_start; m_done = bus_b.fp_done; m_busy = bus_b.busy;
            m_err = bus_b.seq_err; m_layer = bus_b.tile_layer; m_base = bus_b.tile_base;
            m_count = bus_b.tile_count;
        end else begin
            m_start = bus_a.tile_start; m_done = bus_a.fp_done; m_busy = bus_a.busy;
            m_err = bus_a.seq_err; m_layer = bus_a.tile_layer; m_base = bus_a.tile_base;
            m_count = bus_a.tile_count;
        end
    end

    function automatic void build_exp(input int s);
        grp_t g;
        int   n;
        exp_q.delete();
        for (int l = 0; l < 2; l++) begin
            n = (s == 1) ? nb[l] : na[l];
            for (int b = 0; b < n; b += G) begin
                g.l = l;
                g.b = b;
                g.c = (n - b < G) ? n - b : G;
                exp_q.push_back(g);
            end
        end
    endfunction

    task automatic run_pass(input int dly, input bit stray, output int total);
        int   cyc;
        int   d;
        grp_t g;
        build_exp(sel);
        checks++;
        if (m_busy !== 1'b0) begin
            errors++; $display("FAIL pass_idle busy got %0b want 0", m_busy);
        end
        do_fp_v = 1'b1;
        @(negedge clk);
        do_fp_v = 1'b0;
        cyc = 1;
        foreach (exp_q[i]) begin
            g = exp_q[i];
            checks++;
            if (m_start !== 1'b1 || m_busy !== 1'b1 || m_layer !== 2'(g.l) ||
                m_base !== 8'(g.b) || m_count !== CW'(g.c)) begin
                errors++;
                $display("FAIL issue[%0d] got start=%0b busy=%0b l=%0d b=%0d c=%0d want start=1 busy=1 l=%0d b=%0d c=%0d",
                         i, m_start, m_busy, m_layer, m_base, m_count, g.l, g.b, g.c);
            end
            if (stray) begin
                tile_done_v = 1'b1;
                do_fp_v     = 1'b1;
            end
            d = (dly > 0) ? dly : int'($urandom_range(4, 1));
            for (int k = 1; k <= d; k++) begin
                @(negedge clk);
                cyc++;
                tile_done_v = 1'b0;
                do_fp_v     = stray ? 1'($urandom_range(1, 0)) : 1'b0;
                checks++;
                if (m_start !== 1'b0 || m_busy !== 1'b1 || m_done !== 1'b0 || m_err !== 1'b0) begin
                    errors++;
                    $display("FAIL wait[%0d] got start=%0b busy=%0b done=%0b err=%0b want 0 1 0 0",
                             i, m_start, m_busy, m_done, m_err);
                end
                if (k == d) tile_done_v = 1'b1;
            end
            @(negedge clk);
            cyc++;
            tile_done_v = 1'b0;
            do_fp_v     = 1'b0;
        end
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b1 || m_start !== 1'b0) begin
            errors++;
            $display("FAIL fp_done got done=%0b busy=%0b start=%0b want 1 1 0", m_done, m_busy, m_start);
        end
        total = cyc;
        @(negedge clk);
        checks++;
        if (m_done !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done got done=%0b busy=%0b want 0 0", m_done, m_busy);
        end
        if (dly > 0) begin
            checks++;
            if (total != 1 + exp_q.size() * (dly + 1)) begin
                errors++;
                $display("FAIL pass_latency got %0d want %0d", total, 1 + exp_q.size() * (dly + 1));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (m_start !== 1'b0 || m_done !== 1'b0 || m_busy !== 1'b0 || m_err !== 1'b0 ||
            m_layer !== 2'd0 || m_base !== 8'd0 || m_count !== '0) begin
            errors++;
            $display("FAIL reset_state got start=%0b done=%0b busy=%0b err=%0b l=%0d b=%0d c=%0d want all 0",
                     m_start, m_done, m_busy, m_err, m_layer, m_base, m_count);
        end
        rst = 1'b0;
        tile_done_v = 1'b1;
        @(negedge clk);
        tile_done_v = 1'b0;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_tile_done got start=%0b busy=%0b want 0 0", m_start, m_busy);
        end
    endtask

    task automatic test_full_pass();
        int t;
        sel = 0;
        run_pass(3, 1'b0, t);
    endtask

    task automatic test_back_to_back();
        int t;
        sel = 0;
        run_pass(1, 1'b0, t);
        checks++;
        if (t != 13) begin
            errors++; $display("FAIL b2b_latency got %0d want 13", t);
        end
    endtask

    task automatic test_stray_inputs();
        int t;
        sel = 0;
        run_pass(2, 1'b1, t);
    endtask

    task automatic test_reset_mid_pass();
        int t;
        sel = 0;
        do_fp_v = 1'b1;
        @(negedge clk);
        do_fp_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tile_done_v = 1'b1;
            @(negedge clk);
            tile_done_v = 1'b0;
        end
        checks++;
        if (m_start !== 1'b1 || m_layer !== 2'd1 || m_base !== 8'd0 || m_count !== CW'(8)) begin
            errors++;
            $display("FAIL mid_issue got start=%0b l=%0d b=%0d c=%0d want 1 1 0 8", m_start, m_layer, m_base, m_count);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_start !== 1'b0 || m_done !== 1'b0 || m_busy !== 1'b0 || m_err !== 1'b0 ||
            m_layer !== 2'd0 || m_base !== 8'd0 || m_count !== '0) begin
            errors++;
            $display("FAIL async_reset got start=%0b done=%0b busy=%0b err=%0b l=%0d b=%0d c=%0d want all 0",
                     m_start, m_done, m_busy, m_err, m_layer, m_base, m_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tile_done_v = 1'b1;
        @(negedge clk);
        tile_done_v = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_start !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL late_tile_done got start=%0b busy=%0b done=%0b want 0 0 0", m_start, m_busy, m_done);
            end
            @(negedge clk);
        end
        run_pass(2, 1'b0, t);
    endtask

    task automatic test_empty_layer();
        int t;
        sel = 1;
        run_pass(2, 1'b0, t);
        checks++;
        if (t != 13) begin
            errors++; $display("FAIL empty_layer_latency got %0d want 13", t);
        end
        sel = 0;
    endtask

    task automatic test_timeout();
        int t;
        sel = 0;
        do_fp_v = 1'b1;
        @(negedge clk);
        do_fp_v = 1'b0;
        @(negedge clk);
        tile_done_v = 1'b1;
        @(negedge clk);
        tile_done_v = 1'b0;
        checks++;
        if (m_start !== 1'b1 || m_base !== 8'd8) begin
            errors++; $display("FAIL to_issue got start=%0b b=%0d want 1 8", m_start, m_base);
        end
`ifdef SEQ_TIMEOUT_EN
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            checks++;
            if (m_busy !== 1'b1 || m_err !== 1'b0) begin
                errors++; $display("FAIL to_wait[%0d] got busy=%0b err=%0b want 1 0", j, m_busy, m_err);
            end
        end
        @(negedge clk);
        checks++;
        if (m_err !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++; $display("FAIL to_err got err=%0b busy=%0b done=%0b want 1 0 0", m_err, m_busy, m_done);
        end
        @(negedge clk);
        checks++;
        if (m_err !== 1'b0 || m_busy !== 1'b0) begin
            errors++; $display("FAIL to_err_pulse got err=%0b busy=%0b want 0 0", m_err, m_busy);
        end
`else
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            checks++;
            if (m_busy !== 1'b1 || m_err !== 1'b0 || m_start !== 1'b0) begin
                errors++; $display("FAIL no_to_wait[%0d] got busy=%0b err=%0b start=%0b want 1 0 0", j, m_busy, m_err, m_start);
            end
        end
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        run_pass(1, 1'b0, t);
    endtask

    task automatic test_random();
        int t;
        for (int r = 0; r < 6; r++) begin
            sel = (r % 3 == 2) ? 1 : 0;
            run_pass(0, 1'($urandom_range(1, 0)), t);
            for (int k = int'($urandom_range(2, 0)); k > 0; k--) @(negedge clk);
        end
        sel = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_pass();
        test_back_to_back();
        test_stray_inputs();
        test_reset_mid_pass();
        test_empty_layer();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
